snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Top-level game sequencer for the snake game. Consumes the registered
//  goodColl/badColl flags from the collision checker and the step tick,
//  then decides per step whether the snake moves, grows or dies. Drives
//  move/grow/apple-respawn strobes to the snake body and apple logic, and
//  keeps score, length and game state for the display path.
// PARAMETERS
//  MAX_LEN    50  snake length (segments) at which the game is won; range 2..127
//  INIT_LEN   2   snake length after start; must be < MAX_LEN
//  SCORE_W    7   score/length counter width; 2**SCORE_W-1 >= MAX_LEN
// PORTS
//  clk            in   1        system clock
//  nRst           in   1        async active-low reset
//  start_btn      in   1        debounced, synchronized level; rising edge = start
//  pause_btn      in   1        debounced, synchronized level; rising edge = toggle pause
//  move_tick      in   1        1-cycle pulse, one per snake step
//  goodColl       in   1        head-on-apple flag (level, any cycle)
//  badColl        in   1        head-on-body/border flag (level, any cycle)
//  state          out  2        00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
//  move_en        out  1        1-cycle strobe: advance snake one cell
//  grow           out  1        1-cycle strobe coincident with move_en: append segment
//  apple_respawn  out  1        1-cycle strobe coincident with grow
//  score          out  SCORE_W  apples eaten this game
//  length         out  SCORE_W  current snake length
//  game_over      out  1        level: OVER reached by badColl
//  win            out  1        level: OVER reached by length == MAX_LEN
// BEHAVIOUR
//  Reset: state=IDLE; score=0; length=INIT_LEN; all strobes, game_over,
//   win, pending flags and edge-detect history registers = 0.
//  Edge detect: btn_rise = btn & ~btn_q; btn_q reg per button.
//  IDLE: start rise -> RUN; score<=0, length<=INIT_LEN, game_over/win<=0,
//   pending flags cleared. move_tick/collisions ignored.
//  RUN: pend_good set on any cycle goodColl=1; pend_bad on badColl=1;
//   flags hold until the next move_tick is consumed.
//   On move_tick (cycle T), registered outputs at T+1:
//    pend_bad (or badColl at T)  -> state OVER, game_over=1, no move_en.
//    else pend_good (or goodColl at T) -> move_en=grow=apple_respawn=1,
//      score+1, length+1; if new length == MAX_LEN -> OVER, win=1.
//    else -> move_en=1 only.
//   Both flags set in one step: bad wins (no grow, no score).
//   Flags cleared at T+1 regardless of outcome.
//   pause rise -> PAUSE (same-cycle move_tick is dropped, flags kept).
//  PAUSE: no strobes; collision inputs ignored; pause rise -> RUN;
//   start rise ignored.
//  OVER: outputs frozen (score/length/game_over/win hold); start rise ->
//   RUN with the IDLE-start initialisation.
//  Strobes are single-cycle; never asserted outside RUN->(RUN|OVER) step.
//  score and length saturate at 2**SCORE_W-1 (unreachable when params legal).
//  start and pause rise in same cycle: start has priority only in IDLE/OVER;
//   pause has priority in RUN.
//  Async reset mid-game returns to IDLE immediately; no strobe escapes.
// TESTING
//  1 reset, start rise, 3 move_ticks, no coll -> 3 move_en pulses each at
//    tick+1, grow=0, score=0, length=2, state=01.
//  2 goodColl 1 cycle between ticks -> next tick+1: move_en=grow=
//    apple_respawn=1, score=1, length=3; following tick: grow=0.
//  3 goodColl and badColl in same step -> state=11, game_over=1, score
//    unchanged, move_en never pulses; later start rise -> RUN, score=0, length=2.
//  4 MAX_LEN=4: two apple steps -> length=4, state=11, win=1, game_over=0.
//  5 pause rise same cycle as move_tick -> no move_en, state=10; goodColl
//    while paused ignored; pause rise -> RUN, next tick move_en only.
//  6 nRst low mid-RUN with pend_good set -> state=00, score=0, length=2,
//    no grow after release until start.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: per-step game sequencer for the snake game.
//   Latches collision flags between move ticks and decides on each tick
//   whether the snake moves, grows or dies. Keeps score, length and the
//   IDLE/RUN/PAUSE/OVER game state for the display path.
// Ports:
//   clk, nRst                   clock, async active-low reset
//   start_btn, pause_btn        debounced levels; rising edges start / toggle pause
//   move_tick                   1-cycle pulse per snake step
//   goodColl, badColl           apple hit / body-or-border hit levels
//   state                       00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
//   move_en, grow, apple_respawn  1-cycle step strobes
//   score, length               apples eaten / current snake length
//   game_over, win              levels describing how OVER was reached
module snake_game_ctrl #(
  parameter int MAX_LEN  = 50,
  parameter int INIT_LEN = 2,
  parameter int SCORE_W  = 7
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               move_tick,
  input  logic               goodColl,
  input  logic               badColl,
  output logic [1:0]         state,
  output logic               move_en,
  output logic               grow,
  output logic               apple_respawn,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] length,
  output logic               game_over,
  output logic               win
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, OVER = 2'b11} state_t;
  state_t st, stNext;
  logic startQ, pauseQ, pendGood, pendBad;
  logic pendGoodNext, pendBadNext, moveEnNext, growNext, respawnNext, gameOverNext, winNext;
  logic [SCORE_W-1:0] scoreNext, lengthNext, scoreInc, lengthInc;
  logic startRise, pauseRise, hitBad, hitGood;
  assign state     = st;
  assign startRise = start_btn & ~startQ;
  assign pauseRise = pause_btn & ~pauseQ;
  // A collision on the tick cycle itself counts for that step.
  assign hitBad    = pendBad | badColl;
  assign hitGood   = pendGood | goodColl;
  assign scoreInc  = &score ? score : score + 1'b1;
  assign lengthInc = &length ? length : length + 1'b1;
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      st            <= IDLE;
      score         <= '0;
      length        <= SCORE_W'(INIT_LEN);
      move_en       <= 1'b0;
      grow          <= 1'b0;
      apple_respawn <= 1'b0;
      game_over     <= 1'b0;
      win           <= 1'b0;
      pendGood      <= 1'b0;
      pendBad       <= 1'b0;
      startQ        <= 1'b0;
      pauseQ        <= 1'b0;
    end else begin
      st            <= stNext;
      score         <= scoreNext;
      length        <= lengthNext;
      move_en       <= moveEnNext;
      grow          <= growNext;
      apple_respawn <= respawnNext;
      game_over     <= gameOverNext;
      win           <= winNext;
      pendGood      <= pendGoodNext;
      pendBad       <= pendBadNext;
      startQ        <= start_btn;
      pauseQ        <= pause_btn;
    end
  end
  always_comb begin
    stNext       = st;
    scoreNext    = score;
    lengthNext   = length;
    moveEnNext   = 1'b0;
    growNext     = 1'b0;
    respawnNext  = 1'b0;
    gameOverNext = game_over;
    winNext      = win;
    pendGoodNext = pendGood;
    pendBadNext  = pendBad;
    unique case (st)
      IDLE, OVER: begin
        if (startRise) begin
          stNext       = RUN;
          scoreNext    = '0;
          lengthNext   = SCORE_W'(INIT_LEN);
          gameOverNext = 1'b0;
          winNext      = 1'b0;
          pendGoodNext = 1'b0;
          pendBadNext  = 1'b0;
        end
      end
      RUN: begin
        if (pauseRise) begin
          // Tick on this cycle is dropped; flags keep accumulating.
          stNext       = PAUSE;
          pendGoodNext = hitGood;
          pendBadNext  = hitBad;
        end else if (move_tick) begin
          pendGoodNext = 1'b0;
          pendBadNext  = 1'b0;
          if (hitBad) begin
            stNext       = OVER;
            gameOverNext = 1'b1;
          end else begin
            moveEnNext = 1'b1;
            if (hitGood) begin
              growNext    = 1'b1;
              respawnNext = 1'b1;
              scoreNext   = scoreInc;
              lengthNext  = lengthInc;
              if (lengthInc == SCORE_W'(MAX_LEN)) begin
                stNext  = OVER;
                winNext = 1'b1;
              end
            end
          end
        end else begin
          pendGoodNext = hitGood;
          pendBadNext  = hitBad;
        end
      end
      PAUSE: stNext = pauseRise ? RUN : PAUSE;
      default: stNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed scenarios plus random play against a step-level game model.
module tb_snake_game_ctrl;
  localparam int MAX_LEN = 5, INIT_LEN = 2, SCORE_W = 7;
  logic clk = 1'b0, nRst = 1'b0;
  logic startBtn = 1'b0, pauseBtn = 1'b0, moveTick = 1'b0, goodColl = 1'b0, badColl = 1'b0;
  logic [1:0] state;
  logic moveEn, grow, appleRespawn, gameOver, win;
  logic [SCORE_W-1:0] score, length;
  int nChecks = 0, nFails = 0;
  snake_game_ctrl #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .nRst(nRst), .start_btn(startBtn), .pause_btn(pauseBtn), .move_tick(moveTick),
    .goodColl(goodColl), .badColl(badColl), .state(state), .move_en(moveEn), .grow(grow),
    .apple_respawn(appleRespawn), .score(score), .length(length), .game_over(gameOver), .win(win)
  );
  always #5 clk = ~clk;
  // Game model: "playing"/"paused"/"ended" plus what happened on the last step.
  bit playing, paused, ended, endedByWin, sawApple, sawCrash, prevStart, prevPause, stepped, ate;
  int apples;
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      playing = 0; paused = 0; ended = 0; endedByWin = 0; sawApple = 0; sawCrash = 0;
      prevStart = 0; prevPause = 0; stepped = 0; ate = 0; apples = 0;
    end else begin
      stepped = 0;
      ate = 0;
      if (!playing && !paused) begin
        if (startBtn && !prevStart) begin
          playing = 1; ended = 0; endedByWin = 0; apples = 0; sawApple = 0; sawCrash = 0;
        end
      end else if (paused) begin
        if (pauseBtn && !prevPause) begin paused = 0; playing = 1; end
      end else begin
        sawApple |= goodColl;
        sawCrash |= badColl;
        if (pauseBtn && !prevPause) begin
          paused = 1; playing = 0;
        end else if (moveTick) begin
          if (sawCrash) begin
            playing = 0; ended = 1;
          end else begin
            stepped = 1;
            if (sawApple) begin
              ate = 1;
              apples++;
              if (INIT_LEN + apples == MAX_LEN) begin playing = 0; ended = 1; endedByWin = 1; end
            end
          end
          sawApple = 0; sawCrash = 0;
        end
      end
      prevStart = startBtn;
      prevPause = pauseBtn;
    end
  end
  task automatic check(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, wanted %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic checkAll();
    check("state", int'(state), playing ? 1 : paused ? 2 : ended ? 3 : 0);
    check("move_en", int'(moveEn), int'(stepped));
    check("grow", int'(grow), int'(ate));
    check("apple_respawn", int'(appleRespawn), int'(ate));
    check("score", int'(score), apples);
    check("length", int'(length), INIT_LEN + apples);
    check("game_over", int'(gameOver), int'(ended && !endedByWin));
    check("win", int'(win), int'(endedByWin));
  endtask
  task automatic cyc(input bit s, input bit p, input bit t, input bit g, input bit b);
    startBtn = s; pauseBtn = p; moveTick = t; goodColl = g; badColl = b;
    @(negedge clk);
    checkAll();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask
  task automatic tick();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask
  initial begin
    bit t;
    @(negedge clk);
    checkAll();
    nRst = 1'b1;
    idle(2);
    // 1: start, three plain steps
    cyc(1, 0, 0, 0, 0); idle(1);
    repeat (3) begin tick(); idle(1); end
    // 2: one apple between ticks, then a plain step
    cyc(0, 0, 0, 1, 0); idle(1); tick(); tick();
    // 3: apple and crash in the same step, then restart
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1); idle(1); tick(); tick(); idle(2);
    cyc(1, 0, 0, 0, 0); idle(1);
    // 4: eat to MAX_LEN for a win
    repeat (3) begin cyc(0, 0, 0, 1, 0); tick(); end
    idle(2);
    cyc(1, 0, 0, 0, 0); idle(1);
    // 5: pause on a tick, apple ignored while paused, resume
    cyc(0, 1, 1, 0, 0); idle(1); cyc(0, 0, 0, 1, 0); tick();
    cyc(1, 1, 0, 0, 0); idle(1); tick();
    // 6: reset with an apple pending, then no growth until start
    cyc(0, 0, 0, 1, 0);
    #1 nRst = 1'b0;
    @(negedge clk); checkAll();
    nRst = 1'b1;
    tick(); cyc(0, 0, 0, 1, 0); tick();
    cyc(1, 0, 0, 0, 0); tick();
    // random play
    t = 0;
    for (int i = 0; i < 4000; i++) begin
      t = !t && ($urandom_range(3) == 0);
      cyc($urandom_range(7) == 0, $urandom_range(19) == 0, t,
          $urandom_range(7) == 0, $urandom_range(39) == 0);
      if ($urandom_range(599) == 0) begin
        #1 nRst = 1'b0;
        #2 nRst = 1'b1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
